ysyx_22050019_ifu: RTL and testbench
====================================

# ysyx_22050019_ifu

Instruction fetch unit sitting directly upstream of the instruction cache. Holds the PC, issues one 8-byte-aligned read at a time on the cache's AR/R handshake, selects the 32-bit instruction from the returned 64-bit word, and presents it to decode on a valid/ready handshake. Redirects from the back end (branch, jump, trap) are absorbed at any point, including while a cache read is in flight.

## Interface
- ADDR_WIDTH, 64, PC and fetch-address width
- DATA_WIDTH, 64, cache read-data width
- INST_WIDTH, 32, instruction width
- RESET_PC, 64'h8000_0000, first fetch address

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- redirect_valid_i  in  1  back end requests a PC change this cycle
- redirect_pc_i  in  ADDR_WIDTH  new PC; bits [1:0] ignored (treated as 0)
- ar_valid_o  out  1  fetch request to icache
- ar_ready_i  in  1  icache accepts request
- ar_addr_o  out  ADDR_WIDTH  {pc[ADDR_WIDTH-1:3],3'b0}
- r_data_valid_i  in  1  icache read data valid
- r_data_ready_o  out  1  IFU accepts read data
- r_resp_i  in  2  read response; nonzero = error
- r_data_i  in  DATA_WIDTH  aligned 64-bit fetch word
- inst_valid_o  out  1  instruction valid to decode
- inst_ready_i  in  1  decode accepts instruction
- inst_o  out  INST_WIDTH  fetched instruction
- pc_o  out  ADDR_WIDTH  PC of inst_o
- inst_err_o  out  1  r_resp_i was nonzero for this instruction

## Operation
- States: IDLE, REQ, WAIT, OUT, DROP. At most one cache transaction outstanding; no prefetch.
- All outputs registered. Internal pc register; pc[1:0] always 0.
- IDLE: entered only from reset; next cycle -> REQ with ar_valid_o=1, ar_addr_o from pc.
- REQ: ar_valid_o held 1 until ar_valid_o&ar_ready_i; then ar_valid_o<=0, r_data_ready_o<=1 -> WAIT.
  - Redirect, no handshake: pc and ar_addr_o take redirect_pc; stay REQ (icache samples address only on handshake).
  - Redirect with handshake same cycle: pc<=redirect_pc -> DROP.
- WAIT: on r_data_valid_i&r_data_ready_o: r_data_ready_o<=0; inst_o<=pc[2] ? r_data_i[63:32] : r_data_i[31:0]; pc_o<=pc; inst_err_o<=(r_resp_i!=0); inst_valid_o<=1 -> OUT.
  - Redirect, no handshake: pc<=redirect_pc -> DROP (r_data_ready_o stays 1).
  - Redirect with handshake: data discarded, pc<=redirect_pc, r_data_ready_o<=0, ar_valid_o<=1 -> REQ.
- DROP: r_data_ready_o=1; on R handshake data discarded, r_data_ready_o<=0, ar_valid_o<=1 with current pc -> REQ. Further redirects in DROP only update pc (last wins).
- OUT: inst_valid_o, inst_o, pc_o, inst_err_o held stable until inst_ready_i.
  - Handshake: inst_valid_o<=0, pc<=pc+4, ar_valid_o<=1 -> REQ.
  - Redirect, no handshake: instruction squashed (inst_valid_o<=0), pc<=redirect_pc -> REQ.
  - Redirect with handshake: instruction counts as delivered; next fetch uses redirect_pc, not pc+4.
- Arithmetic: pc+4 wraps modulo 2^ADDR_WIDTH.
- inst_err_o does not stall or change flow; back end handles the error.

## Timing
- Reset (rst=0), applied asynchronously: state=IDLE, pc=RESET_PC, ar_valid_o=0, ar_addr_o=0, r_data_ready_o=0, inst_valid_o=0, inst_o=0, pc_o=0, inst_err_o=0. Reset mid-transaction abandons it; icache is reset in the same domain.
- First ar_valid_o=1 on the second rising edge after rst deasserts.
- R handshake in cycle T -> inst_valid_o=1 in T+1.
- Inst handshake in T -> ar_valid_o=1 in T+1 with next address.
- ar_valid_o and r_data_ready_o are never high together; inst_valid_o is never high while ar_valid_o or r_data_ready_o is high.
- Redirect is sampled on every edge in every state except IDLE, where it is ignored.

## Test plan
- Reset release, icache always ready with 0-wait hit: first ar_addr_o=0x8000_0000; r_data_i=0x00500093_00000013 -> inst_o=0x00000013, pc_o=0x8000_0000; next fetch address 0x8000_0000, inst_o=0x00500093, pc_o=0x8000_0004.
- Decode backpressure: inst_ready_i=0 for 5 cycles -> inst_valid_o/inst_o/pc_o stable, ar_valid_o=0 throughout; release -> ar_valid_o=1 the next cycle.
- Redirect in WAIT to 0x8000_0100 (no same-cycle data): next R data is discarded, no inst_valid_o, next ar_addr_o=0x8000_0100.
- Redirect coincident with inst handshake at pc 0x8000_0008, target 0x8000_0040: instruction delivered once, next ar_addr_o=0x8000_0040.
- r_resp_i=2'b10 on a fetch -> inst_err_o=1 with that instruction; next instruction inst_err_o=0.
- pc=0xFFFF_FFFF_FFFF_FFFC consumed -> next ar_addr_o=0; rst asserted mid-WAIT -> all outputs zero immediately, refetch from RESET_PC.

Source files
------------

// File: rtl/ysyx_22050019_ifu.sv
// Instruction fetch unit: holds the PC, issues one aligned icache read at a time,
// and hands the selected 32-bit instruction to decode. Back-end redirects are accepted in any non-idle state.
module ysyx_22050019_ifu #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  ar_valid_o,
  input  logic                  ar_ready_i,
  output logic [ADDR_WIDTH-1:0] ar_addr_o,
  input  logic                  r_data_valid_i,
  output logic                  r_data_ready_o,
  input  logic [1:0]            r_resp_i,
  input  logic [DATA_WIDTH-1:0] r_data_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  inst_err_o
);

  // state | meaning
  // IDLE  | after reset; waits two edges, then issues the first fetch
  // REQ   | ar_valid_o high, waiting for the icache to accept the address
  // WAIT  | request accepted, r_data_ready_o high, waiting for read data
  // OUT   | instruction presented to decode, held until accepted or squashed
  // DROP  | read in flight was redirected away; swallow its data, then refetch
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_DROP
  } state_t;

  state_t                state;
  logic                  armed;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] redir_pc;
  logic [ADDR_WIDTH-1:0] hold_or_redir_pc;
  logic [ADDR_WIDTH-1:0] next_or_redir_pc;
  logic                  ar_hs;
  logic                  r_hs;
  logic                  inst_hs;

  function automatic logic [ADDR_WIDTH-1:0] line_addr(input logic [ADDR_WIDTH-1:0] a);
    return {a[ADDR_WIDTH-1:3], 3'b000};
  endfunction

  assign redir_pc         = redirect_pc_i & ~ADDR_WIDTH'(3);
  assign hold_or_redir_pc = redirect_valid_i ? redir_pc : pc;
  assign next_or_redir_pc = redirect_valid_i ? redir_pc : pc + ADDR_WIDTH'(4);
  assign ar_hs            = ar_valid_o & ar_ready_i;
  assign r_hs             = r_data_valid_i & r_data_ready_o;
  assign inst_hs          = inst_valid_o & inst_ready_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      armed          <= 1'b0;
      pc             <= RESET_PC;
      ar_valid_o     <= 1'b0;
      ar_addr_o      <= '0;
      r_data_ready_o <= 1'b0;
      inst_valid_o   <= 1'b0;
      inst_o         <= '0;
      pc_o           <= '0;
      inst_err_o     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!armed) begin
            armed <= 1'b1;
          end else begin
            state      <= S_REQ;
            ar_valid_o <= 1'b1;
            ar_addr_o  <= line_addr(pc);
          end
        end

        S_REQ: begin
          if (ar_hs) begin
            ar_valid_o     <= 1'b0;
            r_data_ready_o <= 1'b1;
            if (redirect_valid_i) begin
              pc    <= redir_pc;
              state <= S_DROP;
            end else begin
              state <= S_WAIT;
            end
          end else if (redirect_valid_i) begin
            // icache only samples the address on handshake, so retarget in place
            pc        <= redir_pc;
            ar_addr_o <= line_addr(redir_pc);
          end
        end

        S_WAIT: begin
          if (r_hs) begin
            r_data_ready_o <= 1'b0;
            if (redirect_valid_i) begin
              pc         <= redir_pc;
              ar_valid_o <= 1'b1;
              ar_addr_o  <= line_addr(redir_pc);
              state      <= S_REQ;
            end else begin
              inst_o       <= pc[2] ? r_data_i[INST_WIDTH +: INST_WIDTH]
                                    : r_data_i[0 +: INST_WIDTH];
              pc_o         <= pc;
              inst_err_o   <= |r_resp_i;
              inst_valid_o <= 1'b1;
              state        <= S_OUT;
            end
          end else if (redirect_valid_i) begin
            pc    <= redir_pc;
            state <= S_DROP;
          end
        end

        S_DROP: begin
          if (redirect_valid_i) pc <= redir_pc;
          if (r_hs) begin
            r_data_ready_o <= 1'b0;
            ar_valid_o     <= 1'b1;
            ar_addr_o      <= line_addr(hold_or_redir_pc);
            state          <= S_REQ;
          end
        end

        S_OUT: begin
          // redirect wins over pc+4 whether or not decode took the instruction
          if (inst_hs || redirect_valid_i) begin
            inst_valid_o <= 1'b0;
            pc           <= next_or_redir_pc;
            ar_valid_o   <= 1'b1;
            ar_addr_o    <= line_addr(next_or_redir_pc);
            state        <= S_REQ;
          end
        end

        default: begin
          state          <= S_IDLE;
          armed          <= 1'b0;
          ar_valid_o     <= 1'b0;
          r_data_ready_o <= 1'b0;
          inst_valid_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050019_ifu.sv
// Bench for ysyx_22050019_ifu: directed scenarios plus a randomized run against an
// instruction-stream model (expected PC sequence, memory image, error map).
module tb_ysyx_22050019_ifu;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  logic        ar_valid_o;
  logic        ar_ready_i;
  logic [63:0] ar_addr_o;
  logic        r_data_valid_i;
  logic        r_data_ready_o;
  logic [1:0]  r_resp_i;
  logic [63:0] r_data_i;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [63:0] pc_o;
  logic        inst_err_o;

  int vecs = 0;
  int errs = 0;

  int          ar_rdy_pct = 100;
  int          r_vld_pct  = 100;
  bit          err_rand   = 1'b0;
  logic [63:0] err_addr   = '1;

  ysyx_22050019_ifu dut (
    .clk(clk), .rst(rst),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
    .r_data_valid_i(r_data_valid_i), .r_data_ready_o(r_data_ready_o),
    .r_resp_i(r_resp_i), .r_data_i(r_data_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .inst_o(inst_o), .pc_o(pc_o), .inst_err_o(inst_err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] hash32(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  // memory image: word at 8-byte address a holds instructions for a and a+4
  function automatic logic [63:0] mem_word(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h0050_0093_0000_0013;
    return {hash32(a + 64'd4), hash32(a)};
  endfunction

  function automatic logic [1:0] resp_of(input logic [63:0] a);
    if (a == err_addr) return 2'b10;
    if (err_rand && a[5:3] == 3'b011) return a[7] ? 2'b01 : 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [63:0] align8(input logic [63:0] a);
    return a & ~64'd7;
  endfunction

  function automatic logic [31:0] exp_inst(input logic [63:0] pc);
    logic [63:0] w;
    w = mem_word(align8(pc));
    return pc[2] ? w[63:32] : w[31:0];
  endfunction

  // icache responder: one outstanding read, random acceptance and data latency
  bit          samp_ar, samp_r, pend;
  logic [63:0] samp_addr, pend_addr;
  initial begin
    ar_ready_i = 1'b0; r_data_valid_i = 1'b0; r_data_i = '0; r_resp_i = '0;
    pend = 1'b0; pend_addr = '0;
    forever begin
      @(negedge clk);
      samp_ar   = ar_valid_o && ar_ready_i;
      samp_r    = r_data_valid_i && r_data_ready_o;
      samp_addr = ar_addr_o;
      @(posedge clk);
      #1;
      if (!rst) pend = 1'b0;
      else begin
        if (samp_r) pend = 1'b0;
        if (samp_ar) begin pend = 1'b1; pend_addr = samp_addr; end
      end
      ar_ready_i     = int'($urandom_range(99)) < ar_rdy_pct;
      r_data_valid_i = pend && (int'($urandom_range(99)) < r_vld_pct);
      r_data_i       = pend ? mem_word(pend_addr) : {$urandom, $urandom};
      r_resp_i       = pend ? resp_of(pend_addr) : 2'b00;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ar(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ar_valid_o) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_inst(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (inst_valid_o) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    inst_ready_i = 1'b0; redirect_valid_i = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    vecs++;
    if ({ar_valid_o, r_data_ready_o, inst_valid_o, inst_err_o} !== 4'b0) begin
      errs++; $display("FAIL reset_flags: got %b want 0000", {ar_valid_o, r_data_ready_o, inst_valid_o, inst_err_o});
    end
    vecs++;
    if ({ar_addr_o, pc_o, inst_o} !== '0) begin
      errs++; $display("FAIL reset_data: ar_addr %h pc %h inst %h want all 0", ar_addr_o, pc_o, inst_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    // redirect during IDLE must be ignored
    redirect_valid_i = 1'b1; redirect_pc_i = 64'h1234_5670;
    @(posedge clk); #1;
    vecs++;
    if (ar_valid_o !== 1'b0) begin errs++; $display("FAIL first_edge_ar_valid: got %b want 0", ar_valid_o); end
    @(posedge clk); #1;
    redirect_valid_i = 1'b0;
    vecs++;
    if (ar_valid_o !== 1'b1 || ar_addr_o !== RST_PC) begin
      errs++; $display("FAIL second_edge_ar: valid %b addr %h want 1 %h", ar_valid_o, ar_addr_o, RST_PC);
    end
  endtask

  task automatic test_first_fetch();
    bit ok;
    ar_rdy_pct = 100; r_vld_pct = 100; inst_ready_i = 1'b0; redirect_valid_i = 1'b0;
    do_reset();
    wait_ar(ok);
    vecs++;
    if (!ok || ar_addr_o !== RST_PC) begin errs++; $display("FAIL ff_addr0: ok %b got %h want %h", ok, ar_addr_o, RST_PC); end
    wait_inst(ok);
    vecs++;
    if (!ok || inst_o !== 32'h0000_0013 || pc_o !== RST_PC || inst_err_o !== 1'b0) begin
      errs++; $display("FAIL ff_inst0: ok %b inst %h pc %h err %b want 00000013 %h 0", ok, inst_o, pc_o, inst_err_o, RST_PC);
    end
    inst_ready_i = 1'b1;
    wait_ar(ok);
    vecs++;
    if (!ok || ar_addr_o !== RST_PC) begin errs++; $display("FAIL ff_addr1: ok %b got %h want %h", ok, ar_addr_o, RST_PC); end
    wait_inst(ok);
    vecs++;
    if (!ok || inst_o !== 32'h0050_0093 || pc_o !== 64'h8000_0004) begin
      errs++; $display("FAIL ff_inst1: ok %b inst %h pc %h want 00500093 80000004", ok, inst_o, pc_o);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] held_inst;
    logic [63:0] held_pc;
    inst_ready_i = 1'b0;
    wait_inst(ok);
    held_inst = inst_o; held_pc = pc_o;
    vecs++;
    if (!ok) begin errs++; $display("FAIL bp_wait: no instruction within budget"); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vecs++;
      if ({inst_valid_o, ar_valid_o, inst_o, pc_o} !== {1'b1, 1'b0, held_inst, held_pc}) begin
        errs++; $display("FAIL bp_hold: valid %b ar %b inst %h pc %h want 1 0 %h %h", inst_valid_o, ar_valid_o, inst_o, pc_o, held_inst, held_pc);
      end
    end
    inst_ready_i = 1'b1;
    @(negedge clk);
    vecs++;
    if (ar_valid_o !== 1'b1 || inst_valid_o !== 1'b0 || ar_addr_o !== align8(held_pc + 64'd4)) begin
      errs++; $display("FAIL bp_release: ar %b iv %b addr %h want 1 0 %h", ar_valid_o, inst_valid_o, ar_addr_o, align8(held_pc + 64'd4));
    end
  endtask

  task automatic test_redirect_wait();
    bit ok, seen_inst, seen_ar;
    r_vld_pct = 0;
    @(negedge clk);
    vecs++;
    if (r_data_ready_o !== 1'b1) begin errs++; $display("FAIL rw_in_wait: r_data_ready %b want 1", r_data_ready_o); end
    redirect_valid_i = 1'b1; redirect_pc_i = 64'h8000_0103;
    @(negedge clk);
    redirect_valid_i = 1'b0;
    vecs++;
    if (r_data_ready_o !== 1'b1 || ar_valid_o !== 1'b0) begin
      errs++; $display("FAIL rw_drop: r_ready %b ar %b want 1 0", r_data_ready_o, ar_valid_o);
    end
    r_vld_pct = 100;
    seen_inst = 1'b0; seen_ar = 1'b0;
    for (int i = 0; i < 30 && !seen_ar; i++) begin
      @(negedge clk);
      if (inst_valid_o) seen_inst = 1'b1;
      if (ar_valid_o) seen_ar = 1'b1;
    end
    vecs++;
    if (seen_inst || !seen_ar || ar_addr_o !== 64'h8000_0100) begin
      errs++; $display("FAIL rw_refetch: stray_inst %b ar %b addr %h want 0 1 80000100", seen_inst, seen_ar, ar_addr_o);
    end
    wait_inst(ok);
    vecs++;
    if (!ok || pc_o !== 64'h8000_0100 || inst_o !== exp_inst(64'h8000_0100)) begin
      errs++; $display("FAIL rw_inst: ok %b pc %h inst %h want 80000100 %h", ok, pc_o, inst_o, exp_inst(64'h8000_0100));
    end
  endtask

  task automatic test_redirect_handshake();
    bit ok;
    inst_ready_i = 1'b0; redirect_valid_i = 1'b1; redirect_pc_i = 64'h8000_0008;
    @(negedge clk);
    redirect_valid_i = 1'b0;
    wait_inst(ok);
    vecs++;
    if (!ok || pc_o !== 64'h8000_0008 || inst_o !== exp_inst(64'h8000_0008)) begin
      errs++; $display("FAIL rh_inst: ok %b pc %h inst %h want 80000008 %h", ok, pc_o, inst_o, exp_inst(64'h8000_0008));
    end
    inst_ready_i = 1'b1; redirect_valid_i = 1'b1; redirect_pc_i = 64'h8000_0040;
    @(negedge clk);
    inst_ready_i = 1'b0; redirect_valid_i = 1'b0;
    vecs++;
    if (inst_valid_o !== 1'b0 || ar_valid_o !== 1'b1 || ar_addr_o !== 64'h8000_0040) begin
      errs++; $display("FAIL rh_next: iv %b ar %b addr %h want 0 1 80000040", inst_valid_o, ar_valid_o, ar_addr_o);
    end
    inst_ready_i = 1'b1;
    wait_inst(ok);
    vecs++;
    if (!ok || pc_o !== 64'h8000_0040) begin errs++; $display("FAIL rh_target: ok %b pc %h want 80000040", ok, pc_o); end
  endtask

  task automatic test_error();
    bit ok;
    err_addr = 64'h8000_0200;
    inst_ready_i = 1'b0; redirect_valid_i = 1'b1; redirect_pc_i = 64'h8000_0204;
    @(negedge clk);
    redirect_valid_i = 1'b0;
    wait_inst(ok);
    vecs++;
    if (!ok || inst_err_o !== 1'b1 || pc_o !== 64'h8000_0204 || inst_o !== exp_inst(64'h8000_0204)) begin
      errs++; $display("FAIL err_set: ok %b err %b pc %h inst %h want 1 80000204 %h", ok, inst_err_o, pc_o, inst_o, exp_inst(64'h8000_0204));
    end
    inst_ready_i = 1'b1;
    wait_inst(ok);
    vecs++;
    if (!ok || inst_err_o !== 1'b0 || pc_o !== 64'h8000_0208) begin
      errs++; $display("FAIL err_clear: ok %b err %b pc %h want 0 80000208", ok, inst_err_o, pc_o);
    end
    err_addr = '1;
  endtask

  task automatic test_wrap();
    bit ok;
    inst_ready_i = 1'b0; redirect_valid_i = 1'b1; redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFE;
    @(negedge clk);
    redirect_valid_i = 1'b0;
    wait_inst(ok);
    vecs++;
    if (!ok || pc_o !== 64'hFFFF_FFFF_FFFF_FFFC || inst_o !== exp_inst(64'hFFFF_FFFF_FFFF_FFFC)) begin
      errs++; $display("FAIL wrap_top: ok %b pc %h inst %h want fffffffffffffffc %h", ok, pc_o, inst_o, exp_inst(64'hFFFF_FFFF_FFFF_FFFC));
    end
    inst_ready_i = 1'b1;
    wait_ar(ok);
    vecs++;
    if (!ok || ar_addr_o !== 64'h0) begin errs++; $display("FAIL wrap_addr: ok %b addr %h want 0", ok, ar_addr_o); end
    wait_inst(ok);
    vecs++;
    if (!ok || pc_o !== 64'h0 || inst_o !== exp_inst(64'h0)) begin
      errs++; $display("FAIL wrap_inst: ok %b pc %h inst %h want 0 %h", ok, pc_o, inst_o, exp_inst(64'h0));
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok, in_wait;
    inst_ready_i = 1'b0; r_vld_pct = 0;
    redirect_valid_i = 1'b1; redirect_pc_i = 64'h8000_0300;
    @(negedge clk);
    redirect_valid_i = 1'b0;
    in_wait = 1'b0;
    for (int i = 0; i < 30 && !in_wait; i++) begin
      @(negedge clk);
      if (r_data_ready_o) in_wait = 1'b1;
    end
    #2 rst = 1'b0;
    #1;
    vecs++;
    if (!in_wait || {ar_valid_o, r_data_ready_o, inst_valid_o, inst_err_o, ar_addr_o, inst_o, pc_o} !== '0) begin
      errs++; $display("FAIL rst_mid: in_wait %b ar %b rr %b iv %b addr %h pc %h want all 0", in_wait, ar_valid_o, r_data_ready_o, inst_valid_o, ar_addr_o, pc_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1; r_vld_pct = 100; inst_ready_i = 1'b1;
    wait_ar(ok);
    vecs++;
    if (!ok || ar_addr_o !== RST_PC) begin errs++; $display("FAIL rst_refetch: ok %b addr %h want %h", ok, ar_addr_o, RST_PC); end
    wait_inst(ok);
    vecs++;
    if (!ok || pc_o !== RST_PC || inst_o !== 32'h0000_0013) begin
      errs++; $display("FAIL rst_inst: ok %b pc %h inst %h want %h 00000013", ok, pc_o, inst_o, RST_PC);
    end
  endtask

  // model: the next delivered instruction is always at mpc; delivery adds 4, redirect overrides
  task automatic test_random();
    logic [63:0] mpc, tgt, hold_pc;
    logic [31:0] hold_inst, r;
    bit hold;
    int delivered;
    ar_rdy_pct = 60; r_vld_pct = 50; err_rand = 1'b1;
    hold = 1'b0; delivered = 0; mpc = '0; hold_pc = '0; hold_inst = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      r = $urandom;
      tgt = ($urandom_range(7) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'(r[3:0]))
                                      : (64'h8000_0000 | 64'(r[11:0]));
      inst_ready_i     = (c != 0) && (int'($urandom_range(99)) < 65);
      redirect_valid_i = (c == 0) || (int'($urandom_range(99)) < 8);
      redirect_pc_i    = tgt;
      if (hold) begin
        vecs++;
        if (!(inst_valid_o === 1'b1 && inst_o === hold_inst && pc_o === hold_pc)) begin
          errs++; $display("FAIL rnd_hold: cyc %0d iv %b inst %h pc %h want 1 %h %h", c, inst_valid_o, inst_o, pc_o, hold_inst, hold_pc);
        end
      end
      vecs++;
      if ((ar_valid_o && r_data_ready_o) || (inst_valid_o && (ar_valid_o || r_data_ready_o))) begin
        errs++; $display("FAIL rnd_exclusive: cyc %0d ar %b rr %b iv %b want at most one high", c, ar_valid_o, r_data_ready_o, inst_valid_o);
      end
      if (ar_valid_o && ar_ready_i && !redirect_valid_i) begin
        vecs++;
        if (ar_addr_o !== align8(mpc)) begin
          errs++; $display("FAIL rnd_ar_addr: cyc %0d got %h want %h", c, ar_addr_o, align8(mpc));
        end
      end
      if (inst_valid_o && inst_ready_i) begin
        vecs++;
        if (pc_o !== mpc || inst_o !== exp_inst(mpc) || inst_err_o !== (resp_of(align8(mpc)) != 2'b00)) begin
          errs++; $display("FAIL rnd_inst: cyc %0d pc %h inst %h err %b want %h %h %b", c, pc_o, inst_o, inst_err_o, mpc, exp_inst(mpc), resp_of(align8(mpc)) != 2'b00);
        end
        mpc = mpc + 64'd4;
        delivered++;
      end
      hold = inst_valid_o && !inst_ready_i && !redirect_valid_i;
      hold_inst = inst_o; hold_pc = pc_o;
      if (redirect_valid_i) mpc = tgt & ~64'd3;
    end
    redirect_valid_i = 1'b0;
    vecs++;
    if (delivered < 100) begin errs++; $display("FAIL rnd_progress: delivered %0d want >= 100", delivered); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_redirect_wait();
    test_redirect_handshake();
    test_error();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
